// File: rtl/coh_avg_ctrl.sv
// Coherent averaging controller: accumulates n_frames periods of M samples
// into an M-point array using an external registered adder, then pulses done.
// Sample handshake: din is taken on every rising edge where din_valid=1 and the
// controller is in ACCUM. There is no ready signal. Samples offered in any other
// state are dropped.
module coh_avg_ctrl #(
  parameter int DATA_W = 20,
  parameter int ACC_W  = 30,
  parameter int M      = 256,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             n_frames,
  input  logic [DATA_W-1:0]       din,
  input  logic                    din_valid,
  output logic [ACC_W-1:0]        add_x1,
  output logic [DATA_W-1:0]       add_x2,
  input  logic [ACC_W+DATA_W-1:0] add_y,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [ACC_W-1:0]        rd_data,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   p_q, p_d;
  logic [15:0]         f_q, f_d;
  logic [15:0]         nf_q, nf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ACC_W-1:0]    rd_data_q, rd_data_d;

  // Accumulator storage; deliberately not reset (a new run overwrites it).
  logic [ACC_W-1:0]    mem [M];

  logic                accept;
  logic                last;

  // Sample acceptance and shared-adder operand drive.
  always_comb begin
    accept = (state_q == S_ACCUM) && din_valid;
    last   = accept && (p_q == ADDR_W'(M - 1)) && (f_q == nf_q - 16'd1);
    add_x1 = '0;
    add_x2 = '0;
    if (accept) begin
      // First frame bypasses stale contents so every point is overwritten.
      add_x1 = (f_q == 16'd0) ? '0 : mem[p_q];
      add_x2 = din;
    end
  end

  // Next-state, counters, write-back pipeline and registered read port.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    f_d       = f_q;
    nf_d      = nf_q;
    wr_en_d   = accept;
    wr_addr_d = p_q;
    ovf_d     = ovf_q | (wr_en_q && (|add_y[ACC_W+DATA_W-1:ACC_W]));
    rd_data_d = (32'(rd_addr) < M) ? mem[rd_addr] : '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          p_d     = '0;
          f_d     = '0;
          ovf_d   = 1'b0;
          nf_d    = (n_frames == 16'd0) ? 16'd1 : n_frames;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (p_q == ADDR_W'(M - 1)) begin
            p_d = '0;
            f_d = f_q + 16'd1;
          end else begin
            p_d = p_q + ADDR_W'(1);
          end
          if (last) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      f_q       <= '0;
      nf_q      <= 16'd1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      f_q       <= f_d;
      nf_q      <= nf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Write-back of the adder result one cycle after acceptance (truncated).
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= add_y[ACC_W-1:0];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign rd_data   = rd_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_coh_avg_ctrl.sv
// Directed bench for coh_avg_ctrl with a 4-bit accumulator so that
// wrap-around and overflow are reachable with small sample values.
module tb_coh_avg_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int MM  = 4;
  localparam int ADW = 3;

  logic            clk;
  logic            reset;
  logic            start;
  logic [15:0]     n_frames;
  logic [DW-1:0]   din;
  logic            din_valid;
  logic [AW-1:0]   add_x1;
  logic [DW-1:0]   add_x2;
  logic [AW+DW-1:0] add_y;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [ADW-1:0]  rd_addr;
  logic [AW-1:0]   rd_data;
  logic [1:0]      dbg_state;

  coh_avg_ctrl #(.DATA_W(DW), .ACC_W(AW), .M(MM), .ADDR_W(ADW)) dut (
    .clk(clk), .reset(reset), .start(start), .n_frames(n_frames),
    .din(din), .din_valid(din_valid), .add_x1(add_x1), .add_x2(add_x2),
    .add_y(add_y), .busy(busy), .done(done), .overflow(overflow),
    .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shared adder: registered, one-cycle latency, full width.
  always @(posedge clk) add_y <= (AW+DW)'(add_x1) + (AW+DW)'(add_x2);

  // Done pulse counter
  int done_cnt;
  always @(negedge clk) if (done) done_cnt++;

  // Scoreboard and reference model
  logic [31:0]   exp_q[$];
  logic [AW-1:0] ref_arr[MM];
  int            p_m, f_m;
  logic          ovf_m;
  int            n_pass, n_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic start_run(input logic [15:0] n);
    start = 1'b1;
    n_frames = n;
    @(negedge clk);
    start = 1'b0;
    p_m = 0;
    f_m = 0;
    ovf_m = 1'b0;
    done_cnt = 0;
    chk("busy_after_start", busy, 1);
    chk("ovf_cleared", overflow, 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap);
    logic [AW+DW-1:0] sum;
    logic [AW-1:0]    x1;
    din = d;
    din_valid = 1'b1;
    #1;
    x1 = (f_m == 0) ? '0 : ref_arr[p_m];
    exp_q.push_back(32'(x1));
    chk("add_x1", 32'(add_x1), exp_q.pop_front());
    chk("add_x2", 32'(add_x2), 32'(d));
    sum = (AW+DW)'(x1) + (AW+DW)'(d);
    ref_arr[p_m] = sum[AW-1:0];
    if (sum[AW+DW-1:AW] != '0) ovf_m = 1'b1;
    p_m++;
    if (p_m == MM) begin
      p_m = 0;
      f_m++;
    end
    @(negedge clk);
    din_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      #1;
      chk("busy_stall", busy, 1);
      chk("x2_idle_zero", 32'(add_x2), 0);
      @(negedge clk);
    end
  endtask

  // Entered at the negedge right after the final acceptance edge. done is
  // expected one edge later: accepting cycle, FLUSH, then DONE as the third.
  task automatic finish_run();
    int lat;
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("done_lat", lat, 1);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    chk("overflow", overflow, ovf_m);
    chk("done_cnt", done_cnt, 1);
  endtask

  task automatic readout();
    for (int a = 0; a < MM; a++) begin
      rd_addr = ADW'(a);
      exp_q.push_back(32'(ref_arr[a]));
      @(negedge clk);
      chk("rd_data", 32'(rd_data), exp_q.pop_front());
    end
  endtask

  initial begin
    n_pass = 0; n_chk = 0; done_cnt = 0;
    p_m = 0; f_m = 0; ovf_m = 1'b0;
    reset = 1'b1; start = 1'b0; n_frames = 16'd0; din = '0;
    din_valid = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd", 32'(rd_data), 0);
    chk("rst_x1", 32'(add_x1), 0);
    chk("rst_x2", 32'(add_x2), 0);
    chk("rst_state", 32'(dbg_state), 0);
    reset = 1'b0;
    @(negedge clk);

    // Two frames back to back: 6,8,10,12
    start_run(16'd2);
    for (int i = 1; i <= 8; i++) send(DW'(i), 0);
    finish_run();
    readout();
    rd_addr = ADW'(5);
    @(negedge clk);
    chk("rd_out_of_range", 32'(rd_data), 0);

    // Same run with din_valid toggling
    start_run(16'd2);
    for (int i = 1; i <= 8; i++) send(DW'(i), (i < 8) ? 1 : 0);
    finish_run();
    readout();

    // n_frames = 0 acts as one frame
    start_run(16'd0);
    for (int i = 0; i < 4; i++) send(DW'(5), 0);
    finish_run();
    readout();

    // Overflow with truncation: 9+9 = 18 -> 2
    start_run(16'd2);
    for (int i = 0; i < 8; i++) send(DW'(9), 0);
    finish_run();
    readout();
    chk("ovf_sticky", overflow, 1);

    // Reset mid-run, then a fresh single-frame run
    start_run(16'd2);
    for (int i = 1; i <= 3; i++) send(DW'(i), 0);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_state", 32'(dbg_state), 0);
    chk("midrst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_run(16'd1);
    for (int i = 0; i < 4; i++) send(DW'(7), 0);
    finish_run();
    readout();

    // din_valid in IDLE is ignored
    done_cnt = 0;
    din = DW'(15);
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_x2", 32'(add_x2), 0);
    chk("idle_busy", busy, 0);
    din_valid = 1'b0;
    chk("idle_done", done_cnt, 0);
    readout();

    // start during ACCUM is ignored; same-cycle read/write returns old value
    start_run(16'd1);
    rd_addr = '0;
    send(DW'(1), 0);
    start = 1'b1;
    n_frames = 16'd3;
    send(DW'(2), 0);
    chk("rd_wr_same", 32'(rd_data), 7);
    send(DW'(3), 0);
    start = 1'b0;
    send(DW'(4), 0);
    finish_run();
    readout();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
